hs_dcr_master: RTL and testbench
================================

Name: hs_dcr_master

Overview:
- DCR bus initiator for the hs host-interface register map. It is the requester side that drives DCR_Read, DCR_Write, DCR_ABus and DCR_Sl_DBus toward the DCR slave, and collects Sl_dcrAck and Sl_dcrDBus.
- A local sequencer (bring-up controller or debug engine) issues one access at a time over a valid/ready command port. It receives the read data or a timeout flag over a valid/ready response port.
- It lets on-chip logic program the ring registers (base, cons/prod index, ring_enable, irqen) and poll irqstat, err_sts and dma_state without a CPU.

Parameters:
- C_TIMEOUT, 64: cycles allowed for an ack to assert, or to deassert, before the access is aborted. Legal range 2 to 255.
- C_CNT_W, 8: width of the timeout counter. Must satisfy 2^C_CNT_W > C_TIMEOUT.
- C_RETRY, 2: number of reissues after a timeout. Used only when HS_DCR_RETRY_EN is defined.

Ports:
- sys_clk  in  1  single clock for the whole block.
- sys_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block accepts a command; high only in IDLE.
- cmd_write  in  1  1 = DCR write, 0 = DCR read.
- cmd_addr  in  10  DCR address; bit 9 is the LSB and maps to DCR_ABus[9].
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data captured from Sl_dcrDBus; 0 for writes and for timeouts.
- rsp_timeout  out  1  the access was aborted with no ack, or ack stuck high.
- busy  out  1  high in any state other than IDLE.
- DCR_Read  out  1  read strobe.
- DCR_Write  out  1  write strobe.
- DCR_ABus  out  [0:9]  address.
- DCR_Sl_DBus  out  [0:31]  write data.
- Sl_dcrAck  in  1  slave acknowledge.
- Sl_dcrDBus  in  [0:31]  slave read data; valid while Sl_dcrAck is high.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - DCR_Read, DCR_Write, rsp_valid, rsp_timeout and busy are 0.
  - cmd_ready is 1.
  - DCR_ABus, DCR_Sl_DBus and rsp_rdata are 0.
  - Counter is 0.
- Reset mid-access: the strobes drop in the same instant, and any pending response is discarded.
- All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid && cmd_ready, register addr, wdata and write, clear the counter, and go to ACCESS.
  - The strobe (DCR_Write if write, else DCR_Read) asserts on the next cycle.
- ACCESS:
  - Hold the strobe, address and data stable; the counter increments each cycle.
  - If Sl_dcrAck is sampled high:
    - on a read, capture Sl_dcrDBus into rsp_rdata (on a write, rsp_rdata = 0);
    - deassert the strobe, clear the counter and go to RELEASE.
  - Else if counter == C_TIMEOUT-1:
    - deassert the strobe, set the timeout flag, clear the counter and go to RELEASE.
  - The slave registers its ack, so the minimum time from strobe assert to ack is 1 cycle.
- RELEASE:
  - Wait for Sl_dcrAck to be sampled low, then go to RESP.
  - If the ack is still high at counter == C_TIMEOUT-1, set the timeout flag and go to RESP.
  - A new strobe is never asserted while the ack from the previous access is still high.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_timeout stable.
  - On rsp_valid && rsp_ready, go to IDLE (cmd_ready = 1 on the next cycle).
  - rsp_ready held high gives a best-case back-to-back period of 5 cycles per access (ack after 1).
- DCR_Read and DCR_Write are never high together.
- cmd_valid while busy is ignored; the command is not latched.
- A late ack (after timeout, in RELEASE) does not update rsp_rdata.
- Counter saturates; no wrap-around is possible within the legal parameter range.

Optional Feature:
- HS_DCR_RETRY_EN defined:
  - A timeout in ACCESS goes through RELEASE and then reissues the same command, up to C_RETRY extra times.
  - rsp_timeout is set only when every attempt fails.
  - A retry counter is cleared on command accept.
  - The retry count is not reported.
- HS_DCR_RETRY_EN undefined: the first timeout goes straight to RESP with rsp_timeout = 1, and no retry logic is built.

Test Plan:
- Write, addr 0x002, wdata 0x0000_0001, with a slave model that acks 1 cycle after the strobe:
  - DCR_Write high for exactly 2 cycles, with DCR_ABus = 0x002 and DCR_Sl_DBus = 0x1 held stable;
  - rsp_valid arrives with rsp_timeout = 0 and rsp_rdata = 0.
- Read, addr 0x004, slave returns 0x1234_5678 with an ack delayed 5 cycles:
  - rsp_rdata = 0x1234_5678, rsp_timeout = 0;
  - DCR_Read is deasserted the cycle after the ack is seen.
- Read with no ack, C_TIMEOUT = 64, without HS_DCR_RETRY_EN:
  - the strobe drops after 64 cycles;
  - rsp_timeout = 1, rsp_rdata = 0.
- Same as above with HS_DCR_RETRY_EN and C_RETRY = 2:
  - 3 separate DCR_Read pulses, then rsp_timeout = 1.
- Back-to-back writes with rsp_ready held low for 10 cycles on the first:
  - cmd_ready stays 0 and no second strobe appears until the response is taken;
  - an ack stuck high for 3 cycles after the strobe drops delays the next strobe by 3 cycles.
- Assert sys_rst during ACCESS of a read:
  - DCR_Read = 0 and rsp_valid = 0 immediately;
  - cmd_ready = 1 after reset release;
  - a new read completes normally.

Source files
------------

// File: rtl/hs_dcr_master.sv
// DCR bus initiator: one sequencer command at a time, with an ack/timeout handshake toward the slave.
// Optional reissue-on-timeout is built only when HS_DCR_RETRY_EN is defined.
module hs_dcr_master #(
    parameter int unsigned C_TIMEOUT = 64,
    parameter int unsigned C_CNT_W   = 8
`ifdef HS_DCR_RETRY_EN
    ,
    parameter int unsigned C_RETRY   = 2
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [0:9]  cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        busy,

    output logic        DCR_Read,
    output logic        DCR_Write,
    output logic [0:9]  DCR_ABus,
    output logic [0:31] DCR_Sl_DBus,
    input  logic        Sl_dcrAck,
    input  logic [0:31] Sl_dcrDBus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccess  = 2'd1;
    localparam logic [1:0] StRelease = 2'd2;
    localparam logic [1:0] StResp    = 2'd3;

    localparam logic [C_CNT_W-1:0] CntLast = C_CNT_W'(C_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0] CntMax  = {C_CNT_W{1'b1}};
    localparam logic [C_CNT_W-1:0] CntOne  = C_CNT_W'(1);

    logic [1:0]         state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic               write_q, write_d;
    logic               rd_q, rd_d;
    logic               wr_d, wr_q;
    logic [0:9]         abus_q, abus_d;
    logic [0:31]        dbus_q, dbus_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               cmd_ready_q, cmd_ready_d;

`ifdef HS_DCR_RETRY_EN
    localparam int unsigned RetryW = (C_RETRY < 2) ? 1 : $clog2(C_RETRY + 1);
    localparam logic [RetryW-1:0] RetryLast = RetryW'(C_RETRY);
    localparam logic [RetryW-1:0] RetryOne  = RetryW'(1);

    logic [RetryW-1:0] retry_q, retry_d;
    logic              retry_pend_q, retry_pend_d;
`endif

    // Saturating so a slave that never answers cannot wrap the counter.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        abus_d      = abus_q;
        dbus_d      = dbus_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        cmd_ready_d = cmd_ready_q;
`ifdef HS_DCR_RETRY_EN
        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    write_d     = cmd_write;
                    abus_d      = cmd_addr;
                    dbus_d      = cmd_wdata;
                    cnt_d       = '0;
                    rd_d        = ~cmd_write;
                    wr_d        = cmd_write;
                    rdata_d     = '0;
                    tmo_d       = 1'b0;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = StAccess;
`ifdef HS_DCR_RETRY_EN
                    retry_d      = '0;
                    retry_pend_d = 1'b0;
`endif
                end
            end

            StAccess: begin
                if (Sl_dcrAck) begin
                    rdata_d = write_q ? 32'h0 : Sl_dcrDBus;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRelease;
                end else if (cnt_q == CntLast) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRelease;
`ifdef HS_DCR_RETRY_EN
                    if (retry_q != RetryLast) begin
                        retry_pend_d = 1'b1;
                    end else begin
                        tmo_d = 1'b1;
                    end
`else
                    tmo_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StRelease: begin
                if (!Sl_dcrAck) begin
                    cnt_d = '0;
`ifdef HS_DCR_RETRY_EN
                    if (retry_pend_q) begin
                        // Reissue the latched command; address and data are still held.
                        rd_d         = ~write_q;
                        wr_d         = write_q;
                        retry_d      = retry_q + RetryOne;
                        retry_pend_d = 1'b0;
                        state_d      = StAccess;
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end
`else
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
`endif
                end else if (cnt_q == CntLast) begin
                    cnt_d       = '0;
                    tmo_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
`ifdef HS_DCR_RETRY_EN
                    retry_pend_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StResp: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            abus_q      <= '0;
            dbus_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            abus_q      <= abus_d;
            dbus_q      <= dbus_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

`ifdef HS_DCR_RETRY_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
        end else begin
            retry_q      <= retry_d;
            retry_pend_q <= retry_pend_d;
        end
    end
`endif

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = tmo_q;
    assign busy        = busy_q;
    assign DCR_Read    = rd_q;
    assign DCR_Write   = wr_q;
    assign DCR_ABus    = abus_q;
    assign DCR_Sl_DBus = dbus_q;

endmodule

// File: tb/tb_hs_dcr_master.sv
// Directed bench for hs_dcr_master with a configurable DCR slave model (ack delay, no ack, stuck ack).
// Expectations follow HS_DCR_RETRY_EN the same way the design does.
module tb_hs_dcr_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [0:9]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        busy;
    logic        DCR_Read;
    logic        DCR_Write;
    logic [0:9]  DCR_ABus;
    logic [0:31] DCR_Sl_DBus;
    logic        Sl_dcrAck;
    logic [0:31] Sl_dcrDBus;

    hs_dcr_master #(
        .C_TIMEOUT (64),
        .C_CNT_W   (8)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .DCR_Read    (DCR_Read),
        .DCR_Write   (DCR_Write),
        .DCR_ABus    (DCR_ABus),
        .DCR_Sl_DBus (DCR_Sl_DBus),
        .Sl_dcrAck   (Sl_dcrAck),
        .Sl_dcrDBus  (Sl_dcrDBus)
    );

    always #5 clk = ~clk;

    // Slave model: registered ack after slv_delay strobe cycles, one-cycle pulse unless slv_stuck
    // holds it high that many cycles after the strobe drops.
    int          slv_delay = 1;
    int          slv_stuck = 0;
    logic        slv_no_ack = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_ack;
    int          slv_cnt;
    int          slv_hold;
    logic        strobe;

    assign strobe     = DCR_Read | DCR_Write;
    assign Sl_dcrAck  = slv_ack;
    assign Sl_dcrDBus = slv_ack ? slv_rdata : 32'hDEAD_BEEF;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            slv_ack  <= 1'b0;
            slv_cnt  <= 0;
            slv_hold <= 0;
        end else begin
            slv_cnt <= strobe ? slv_cnt + 1 : 0;
            if (!slv_ack) begin
                if (strobe && !slv_no_ack && (slv_cnt + 1 >= slv_delay)) begin
                    slv_ack  <= 1'b1;
                    slv_hold <= slv_stuck;
                end
            end else if (slv_hold == 0) begin
                slv_ack <= 1'b0;
            end else if (!strobe) begin
                slv_hold <= slv_hold - 1;
                if (slv_hold == 1) slv_ack <= 1'b0;
            end
        end
    end

    int   n_cmp = 0;
    int   n_fail = 0;
    int   rd_cycles, rd_pulses, wr_cycles, wr_pulses, both_hi;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    logic last_ack = 1'b0;
    int   lat;
    int   n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        last_ack = Sl_dcrAck;
        @(posedge clk);
        #1;
        if (DCR_Read) rd_cycles++;
        if (DCR_Write) wr_cycles++;
        if (DCR_Read && !prev_rd) rd_pulses++;
        if (DCR_Write && !prev_wr) wr_pulses++;
        if (DCR_Read && DCR_Write) both_hi++;
        prev_rd = DCR_Read;
        prev_wr = DCR_Write;
    endtask

    task automatic clear_counts();
        rd_cycles = 0;
        rd_pulses = 0;
        wr_cycles = 0;
        wr_pulses = 0;
    endtask

    task automatic issue(input logic wr, input logic [9:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int max, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < max) begin
            tick();
            cycles++;
        end
        check(tag, {31'h0, rsp_valid}, 32'h1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        both_hi = 0;
        clear_counts();

        // Reset values
        tick();
        tick();
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_strobes", {30'h0, DCR_Read, DCR_Write}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_abus", {22'h0, DCR_ABus}, 32'h0);
        check("rst_dbus", DCR_Sl_DBus, 32'h0);
        rst = 1'b0;
        tick();

        // Write 0x002 <- 1, ack one cycle after the strobe
        slv_rdata = 32'h5555_AAAA;
        clear_counts();
        issue(1'b1, 10'h002, 32'h0000_0001);
        check("wr1_strobe_on", {30'h0, DCR_Read, DCR_Write}, 32'h1);
        check("wr1_abus", {22'h0, DCR_ABus}, 32'h002);
        check("wr1_dbus", DCR_Sl_DBus, 32'h1);
        check("wr1_busy", {30'h0, busy, cmd_ready}, 32'h2);
        tick();
        check("wr1_strobe_cyc2", {31'h0, DCR_Write}, 32'h1);
        check("wr1_abus_held", {22'h0, DCR_ABus}, 32'h002);
        tick();
        check("wr1_strobe_off", {31'h0, DCR_Write}, 32'h0);
        wait_rsp("wr1_rsp", 20, lat);
        check("wr1_lat", lat, 1);
        check("wr1_wr_cycles", wr_cycles, 2);
        check("wr1_timeout", {31'h0, rsp_timeout}, 32'h0);
        check("wr1_rdata", rsp_rdata, 32'h0);
        take_rsp();
        check("wr1_idle", {29'h0, rsp_valid, busy, cmd_ready}, 32'h1);

        // Read 0x004, ack after 5 strobe cycles
        slv_delay = 5;
        slv_rdata = 32'h1234_5678;
        clear_counts();
        issue(1'b0, 10'h004, 32'h0);
        check("rd_strobe_on", {30'h0, DCR_Read, DCR_Write}, 32'h2);
        n = 0;
        while (DCR_Read && n < 50) begin
            tick();
            n++;
        end
        check("rd_drop_after_ack", {31'h0, last_ack}, 32'h1);
        check("rd_rd_cycles", rd_cycles, 6);
        wait_rsp("rd_rsp", 20, lat);
        check("rd_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_timeout", {31'h0, rsp_timeout}, 32'h0);
        take_rsp();

        // Read with no ack: times out
        slv_delay  = 1;
        slv_no_ack = 1'b1;
        clear_counts();
        issue(1'b0, 10'h010, 32'h0);
        wait_rsp("tmo_rsp", 400, lat);
`ifdef HS_DCR_RETRY_EN
        check("tmo_pulses", rd_pulses, 3);
        check("tmo_rd_cycles", rd_cycles, 192);
`else
        check("tmo_pulses", rd_pulses, 1);
        check("tmo_rd_cycles", rd_cycles, 64);
`endif
        check("tmo_timeout", {31'h0, rsp_timeout}, 32'h1);
        check("tmo_rdata", rsp_rdata, 32'h0);
        take_rsp();
        slv_no_ack = 1'b0;

        // Back-to-back writes, first response held for 10 cycles
        slv_rdata = 32'h0F0F_0F0F;
        clear_counts();
        issue(1'b1, 10'h008, 32'hA5A5_0001);
        wait_rsp("b2b_a_rsp", 20, lat);
        check("b2b_a_lat", lat, 3);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 10'h00C;
        cmd_wdata = 32'hA5A5_0002;
        for (int i = 0; i < 10; i++) tick();
        check("b2b_hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("b2b_hold_pulses", wr_pulses, 1);
        check("b2b_hold_abus", {22'h0, DCR_ABus}, 32'h008);
        check("b2b_hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        take_rsp();
        check("b2b_ready_again", {31'h0, cmd_ready}, 32'h1);
        slv_stuck = 3;
        tick();
        cmd_valid = 1'b0;
        check("b2b_b_strobe", {31'h0, DCR_Write}, 32'h1);
        check("b2b_b_abus", {22'h0, DCR_ABus}, 32'h00C);
        check("b2b_b_dbus", DCR_Sl_DBus, 32'hA5A5_0002);
        wait_rsp("b2b_b_rsp", 40, lat);
        check("b2b_b_lat_stuck", lat, 6);
        check("b2b_b_timeout", {31'h0, rsp_timeout}, 32'h0);
        check("b2b_pulses", wr_pulses, 2);
        take_rsp();
        slv_stuck = 0;

        // Reset during a read access
        slv_no_ack = 1'b1;
        issue(1'b0, 10'h020, 32'h0);
        tick();
        tick();
        check("rstmid_read_on", {31'h0, DCR_Read}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstmid_read_off", {31'h0, DCR_Read}, 32'h0);
        check("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        slv_no_ack = 1'b0;
        slv_delay  = 2;
        slv_rdata  = 32'hCAFE_F00D;
        issue(1'b0, 10'h3FF, 32'h0);
        check("rstmid_abus", {22'h0, DCR_ABus}, 32'h3FF);
        wait_rsp("rstmid_rsp", 40, lat);
        check("rstmid_rdata", rsp_rdata, 32'hCAFE_F00D);
        check("rstmid_timeout", {31'h0, rsp_timeout}, 32'h0);
        take_rsp();

        check("never_both_strobes", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
